// File: rtl/saturn_bus_ctrl.sv
// saturn_bus_ctrl: nibble-bus sequencer and arbiter for the single memory port.
//
// Shares the port between decoder instruction fetch (PC-addressed, one nibble) and ALU data
// transfers (DAT0/DAT1, 1..16 nibbles, read or write). Commands are asserted on the bus-send
// phase enable and completed or deasserted on the bus-recv phase enable; all other clocks hold
// state. Memory wait states are absorbed by holding the command until i_mem_ready.
//
// Optional feature macro: SATURN_BUS_WDOG_EN
//   Defined   - a per-beat watchdog aborts a beat after WDOG_LIMIT not-ready recv phases and
//               raises the sticky o_bus_error flag.
//   Undefined - the controller waits indefinitely and o_bus_error is tied to 0.
//
// Ports:
//   i_clk, i_reset            core clock, asynchronous active-low reset
//   i_en_bus_send/recv        one-clock phase enables (command issue / completion)
//   i_fetch_req, i_pc         decoder fetch request and address
//   o_fetch_nibble/valid      fetched nibble and its one-clock update pulse
//   i_data_*                  data transfer request: we, start addr, length-1, write nibble
//   o_data_idx/rnib/rvalid    current beat index, read nibble and its pulse
//   o_data_busy/done          transfer in progress, end-of-transfer pulse
//   o_stall                   decoder hold
//   o_mem_*, i_mem_*          memory port: address, rd/wr commands, write data, read data, ready
//   o_bus_error               sticky watchdog abort flag
module saturn_bus_ctrl #(
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned WDOG_LIMIT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_en_bus_send,
  input  logic              i_en_bus_recv,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_pc,
  output logic [3:0]        o_fetch_nibble,
  output logic              o_fetch_valid,
  input  logic              i_data_req,
  input  logic              i_data_we,
  input  logic [ADDR_W-1:0] i_data_addr,
  input  logic [3:0]        i_data_len,
  input  logic [3:0]        i_data_wnib,
  output logic [3:0]        o_data_idx,
  output logic [3:0]        o_data_rnib,
  output logic              o_data_rvalid,
  output logic              o_data_busy,
  output logic              o_data_done,
  output logic              o_stall,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [3:0]        o_mem_wdata,
  input  logic [3:0]        i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_bus_error
);

  typedef enum logic [1:0] {StIdle, StFetch, StData} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [3:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic              we_q, we_d;
  logic [3:0]        rnib_q, rnib_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic [3:0]        fnib_q, fnib_d;
  logic              fvalid_q, fvalid_d;

  logic              cmd_active;
  logic              beat_ok;
  logic              beat_wait;
  logic              wdog_fire;
  logic [ADDR_W-1:0] beat_addr;

  // A beat is outstanding exactly while a command is on the bus.
  assign cmd_active = mem_rd_q | mem_wr_q;
  assign beat_ok    = i_en_bus_recv & cmd_active & i_mem_ready;
  assign beat_wait  = i_en_bus_recv & cmd_active & ~i_mem_ready;
  // Address arithmetic wraps naturally at ADDR_W bits.
  assign beat_addr  = base_q + ADDR_W'(idx_q);

`ifdef SATURN_BUS_WDOG_EN
  localparam int unsigned WdogW = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT + 1) : 1;

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             bus_err_q, bus_err_d;

  // Fires on the recv phase that would make the not-ready count reach WDOG_LIMIT.
  assign wdog_fire = beat_wait && (wdog_q == WdogW'(WDOG_LIMIT - 1));

  always_comb begin
    wdog_d    = wdog_q;
    bus_err_d = bus_err_q;
    if (beat_ok) begin
      wdog_d = '0;
    end else if (beat_wait) begin
      wdog_d = wdog_fire ? '0 : wdog_q + WdogW'(1);
    end
    if (wdog_fire) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wdog_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign o_bus_error = bus_err_q;
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign wdog_fire         = 1'b0;
  assign o_bus_error       = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    base_d      = base_q;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    mem_wdata_d = mem_wdata_q;
    len_d       = len_q;
    idx_d       = idx_q;
    we_d        = we_q;
    rnib_d      = rnib_q;
    fnib_d      = fnib_q;
    rvalid_d    = 1'b0;
    done_d      = 1'b0;
    fvalid_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_en_bus_send) begin
          if (i_data_req) begin
            // Data wins over a simultaneous fetch; beat 0 goes out on this same send phase.
            base_d     = i_data_addr;
            len_d      = i_data_len;
            we_d       = i_data_we;
            idx_d      = '0;
            mem_addr_d = i_data_addr;
            mem_rd_d   = ~i_data_we;
            mem_wr_d   = i_data_we;
            if (i_data_we) begin
              mem_wdata_d = i_data_wnib;
            end
            state_d = StData;
          end else if (i_fetch_req) begin
            mem_addr_d = i_pc;
            mem_rd_d   = 1'b1;
            state_d    = StFetch;
          end
        end
      end

      StFetch: begin
        if (beat_ok) begin
          fnib_d   = i_mem_rdata;
          fvalid_d = 1'b1;
          mem_rd_d = 1'b0;
          state_d  = StIdle;
        end else if (wdog_fire) begin
          mem_rd_d = 1'b0;
          state_d  = StIdle;
        end
      end

      StData: begin
        // A new beat starts only when the previous one has completed; a waiting beat keeps
        // its command, address and write nibble untouched.
        if (i_en_bus_send && !cmd_active) begin
          mem_addr_d = beat_addr;
          mem_rd_d   = ~we_q;
          mem_wr_d   = we_q;
          if (we_q) begin
            mem_wdata_d = i_data_wnib;
          end
        end
        if (beat_ok) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (!we_q) begin
            rnib_d   = i_mem_rdata;
            rvalid_d = 1'b1;
          end
          if (idx_q == len_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else if (wdog_fire) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      base_q      <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      we_q        <= 1'b0;
      rnib_q      <= '0;
      rvalid_q    <= 1'b0;
      done_q      <= 1'b0;
      fnib_q      <= '0;
      fvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      base_q      <= base_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      we_q        <= we_d;
      rnib_q      <= rnib_d;
      rvalid_q    <= rvalid_d;
      done_q      <= done_d;
      fnib_q      <= fnib_d;
      fvalid_q    <= fvalid_d;
    end
  end

  // Fetch stall drops combinationally on the recv clock that completes the beat.
  assign o_stall = (state_q == StData) ||
                   ((state_q == StFetch) && !(i_en_bus_recv && i_mem_ready)) ||
                   ((state_q == StIdle) && i_data_req);

  assign o_fetch_nibble = fnib_q;
  assign o_fetch_valid  = fvalid_q;
  assign o_data_idx     = idx_q;
  assign o_data_rnib    = rnib_q;
  assign o_data_rvalid  = rvalid_q;
  assign o_data_busy    = (state_q == StData);
  assign o_data_done    = done_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_rd       = mem_rd_q;
  assign o_mem_wr       = mem_wr_q;
  assign o_mem_wdata    = mem_wdata_q;

endmodule
